// File: rtl/main_mem_if.sv
// main_mem_if: cache <-> memory controller block request/response bundle.
interface main_mem_if #(
    parameter int BLOCK_BITS = 64,
    parameter int BADDR_BITS = 29
);
    logic                  icache_req_valid;
    logic [BADDR_BITS-1:0] icache_req_block_addr;
    logic                  icache_req_ready;
    logic                  icache_flush;
    logic                  icache_resp_valid;
    logic [BLOCK_BITS-1:0] icache_resp_block_data;
    logic                  dcache_req_valid;
    logic                  dcache_req_type;
    logic [BADDR_BITS-1:0] dcache_req_block_addr;
    logic [BLOCK_BITS-1:0] dcache_req_block_data;
    logic                  dcache_req_ready;
    logic                  dcache_resp_valid;
    logic [BLOCK_BITS-1:0] dcache_resp_block_data;
    modport master (
        output icache_req_valid, icache_req_block_addr, icache_flush,
               dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
        input  icache_req_ready, icache_resp_valid, icache_resp_block_data,
               dcache_req_ready, dcache_resp_valid, dcache_resp_block_data
    );
    modport slave (
        input  icache_req_valid, icache_req_block_addr, icache_flush,
               dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
        output icache_req_ready, icache_resp_valid, icache_resp_block_data,
               dcache_req_ready, dcache_resp_valid, dcache_resp_block_data
    );
endinterface

// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: block memory responder for icache/dcache; icache wins arbitration,
// fixed access latency, one request outstanding at a time.
module main_mem_ctrl #(
    parameter int BLOCK_BITS = 64,
    parameter int BADDR_BITS = 29,
    parameter int MEM_BLOCKS = 1024,
    parameter int LATENCY    = 4
) (
    input  logic      clk,
    input  logic      rst_aH,
    main_mem_if.slave bus
);
    localparam int IW = $clog2(MEM_BLOCKS);
    localparam int CW = $clog2(LATENCY + 1);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  dsel_q, dsel_d, kill_q, kill_d;
    logic [BLOCK_BITS-1:0] idat_q, ddat_q, rd_data;
    logic [BLOCK_BITS-1:0] mem [MEM_BLOCKS];
    logic                  i_acc, d_acc, last;
    // a flush alongside an icache request in IDLE blocks that accept
    assign bus.icache_req_ready = state_q == IDLE && !bus.icache_flush;
    assign bus.dcache_req_ready = state_q == IDLE && !bus.icache_req_valid;
    assign i_acc = bus.icache_req_valid && bus.icache_req_ready;
    assign d_acc = bus.dcache_req_valid && bus.dcache_req_ready;
    assign last  = cnt_q == CW'(LATENCY - 2);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dsel_d  = dsel_q;
        kill_d  = kill_q || (bus.icache_flush && !dsel_q && state_q != IDLE);
        if (state_q == IDLE && (i_acc || d_acc)) begin
            state_d = LATENCY == 1 ? RESP : BUSY;
            cnt_d   = '0;
            dsel_d  = !i_acc;
            idx_d   = i_acc ? bus.icache_req_block_addr[IW-1:0] : bus.dcache_req_block_addr[IW-1:0];
            kill_d  = 1'b0;
        end else if (state_q == BUSY) begin
            state_d = last ? RESP : BUSY;
            cnt_d   = cnt_q + 1'b1;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            dsel_q  <= 1'b0;
            kill_q  <= 1'b0;
            idat_q  <= '0;
            ddat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dsel_q  <= dsel_d;
            kill_q  <= kill_d;
            if (bus.icache_resp_valid) idat_q <= rd_data;
            if (bus.dcache_resp_valid) ddat_q <= rd_data;
        end
    end
    // array survives reset; the write lands on the accept edge so later reads see it
    always_ff @(posedge clk) begin
        if (d_acc && bus.dcache_req_type && !rst_aH)
            mem[bus.dcache_req_block_addr[IW-1:0]] <= bus.dcache_req_block_data;
    end
    assign rd_data = mem[idx_q];
    assign bus.icache_resp_valid      = state_q == RESP && !dsel_q && !kill_q && !bus.icache_flush;
    assign bus.dcache_resp_valid      = state_q == RESP && dsel_q;
    assign bus.icache_resp_block_data = bus.icache_resp_valid ? rd_data : idat_q;
    assign bus.dcache_resp_block_data = bus.dcache_resp_valid ? rd_data : ddat_q;
endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb_main_mem_ctrl: drives LATENCY=4 and LATENCY=1 controllers with identical stimulus and
// checks both against a timestamp-based transaction model.
module tb_main_mem_ctrl;
    typedef struct packed {logic ir; logic dr; logic irv; logic drv; logic [63:0] idat; logic [63:0] ddat;} obs_t;
    typedef struct {logic iv; logic dv; logic fl; logic ir; logic dr; logic irv; logic drv;} vec_t;
    logic clk, rst, iv, fl, dv, dt;
    logic [28:0] ia, da;
    logic [63:0] dd;
    int cyc, n_vec, n_bad;
    int lat [2] = '{4, 1};
    int free_at [2], resp_at [2], m_idx [2];
    bit m_d [2], m_kill [2];
    logic [63:0] last_i [2], last_d [2];
    logic [63:0] ref_mem [2][1024];
    obs_t o4, o1;
    vec_t tbl [19];
    main_mem_if #(.BLOCK_BITS(64), .BADDR_BITS(29)) b4 ();
    main_mem_if #(.BLOCK_BITS(64), .BADDR_BITS(29)) b1 ();
    assign b4.icache_req_valid = iv;      assign b1.icache_req_valid = iv;
    assign b4.icache_req_block_addr = ia; assign b1.icache_req_block_addr = ia;
    assign b4.icache_flush = fl;          assign b1.icache_flush = fl;
    assign b4.dcache_req_valid = dv;      assign b1.dcache_req_valid = dv;
    assign b4.dcache_req_type = dt;       assign b1.dcache_req_type = dt;
    assign b4.dcache_req_block_addr = da; assign b1.dcache_req_block_addr = da;
    assign b4.dcache_req_block_data = dd; assign b1.dcache_req_block_data = dd;
    main_mem_ctrl #(.LATENCY(4)) u4 (.clk(clk), .rst_aH(rst), .bus(b4));
    main_mem_ctrl #(.LATENCY(1)) u1 (.clk(clk), .rst_aH(rst), .bus(b1));
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    function automatic logic [63:0] pre(int a);
        return a == 16 ? 64'hDEADBEEF_CAFEF00D : {32'hA5A5_0000 + 32'(a), ~32'(a)};
    endfunction
    function automatic obs_t obs(int k);
        obs_t o;
        if (k == 0) o = {b4.icache_req_ready, b4.dcache_req_ready, b4.icache_resp_valid, b4.dcache_resp_valid,
                         b4.icache_resp_block_data, b4.dcache_resp_block_data};
        else        o = {b1.icache_req_ready, b1.dcache_req_ready, b1.icache_resp_valid, b1.dcache_resp_valid,
                         b1.icache_resp_block_data, b1.dcache_resp_block_data};
        return o;
    endfunction
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp_v);
        end
    endtask
    // one cycle: check outputs before the next edge, then advance the model across it
    task automatic step();
        obs_t o, e;
        bit idle, resp, ai, ad;
        int t;
        #1;
        t = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                free_at[k] = 0; resp_at[k] = -1; last_i[k] = '0; last_d[k] = '0;
            end
            idle = t >= free_at[k];
            resp = t == resp_at[k];
            e.ir   = idle && !fl;
            e.dr   = idle && !iv;
            e.irv  = resp && !m_d[k] && !m_kill[k] && !fl;
            e.drv  = resp && m_d[k];
            e.idat = e.irv ? ref_mem[k][m_idx[k]] : last_i[k];
            e.ddat = e.drv ? ref_mem[k][m_idx[k]] : last_d[k];
            o = obs(k);
            chk($sformatf("icache_req_ready L%0d", lat[k]), o.ir, e.ir);
            chk($sformatf("dcache_req_ready L%0d", lat[k]), o.dr, e.dr);
            chk($sformatf("icache_resp_valid L%0d", lat[k]), o.irv, e.irv);
            chk($sformatf("dcache_resp_valid L%0d", lat[k]), o.drv, e.drv);
            chk($sformatf("icache_resp_data L%0d", lat[k]), o.idat, e.idat);
            chk($sformatf("dcache_resp_data L%0d", lat[k]), o.ddat, e.ddat);
            if (k == 0) o4 = o; else o1 = o;
            if (fl && !m_d[k] && t <= resp_at[k]) m_kill[k] = 1;
            if (e.irv) last_i[k] = e.idat;
            if (e.drv) last_d[k] = e.ddat;
            ai = !rst && idle && iv && !fl;
            ad = !rst && idle && dv && !iv;
            if (ai || ad) begin
                resp_at[k] = t + lat[k];
                free_at[k] = resp_at[k] + 1;
                m_d[k] = ad;
                m_kill[k] = 0;
                m_idx[k] = int'(ad ? da : ia) % 1024;
                if (ad && dt) ref_mem[k][m_idx[k]] = dd;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask
    task automatic idle_in();
        iv = 0; dv = 0; fl = 0; dt = 0;
    endtask
    task automatic wait_idle();
        idle_in();
        for (int g = 0; g < 20 && (cyc + 1 < free_at[0] || cyc + 1 < free_at[1]); g++) step();
    endtask
    initial begin
        n_vec = 0; n_bad = 0; cyc = 0;
        rst = 1; idle_in(); ia = '0; da = '0; dd = '0;
        for (int k = 0; k < 2; k++) begin
            free_at[k] = 0; resp_at[k] = -1; m_idx[k] = 0; m_d[k] = 0; m_kill[k] = 0;
            last_i[k] = '0; last_d[k] = '0;
            for (int a = 0; a < 1024; a++) ref_mem[k][a] = '0;
        end
        // contention: icache wins, dcache held; then flushed icache read; then flush blocking accept
        tbl = '{
            '{1,1,0, 1,0,0,0}, '{0,1,0, 0,0,0,0}, '{0,1,0, 0,0,0,0}, '{0,1,0, 0,0,0,0},
            '{0,1,0, 0,0,1,0}, '{0,1,0, 1,1,0,0}, '{0,0,0, 0,0,0,0}, '{0,0,0, 0,0,0,0},
            '{0,0,0, 0,0,0,0}, '{0,0,0, 0,0,0,1}, '{0,0,0, 1,1,0,0},
            '{1,0,0, 1,0,0,0}, '{0,0,0, 0,0,0,0}, '{0,0,1, 0,0,0,0}, '{0,0,0, 0,0,0,0},
            '{0,0,0, 0,0,0,0}, '{0,0,0, 1,1,0,0}, '{1,0,1, 0,0,0,0}, '{0,0,0, 1,1,0,0}};
        @(negedge clk);
        step();
        chk("reset icache_req_ready", o4.ir, 1);
        chk("reset dcache_req_ready", o4.dr, 1);
        chk("reset icache data", o4.idat, 0);
        chk("reset dcache data", o4.ddat, 0);
        step();
        rst = 0;
        for (int a = 0; a < 32; a++) begin
            wait_idle();
            dv = 1; dt = 1; da = 29'(a); dd = pre(a);
            step();
        end
        wait_idle();
        iv = 1; ia = 29'h10;
        step();
        iv = 0;
        for (int j = 1; j <= 5; j++) begin
            step();
            chk("t1 icache_resp_valid L4", o4.irv, j == 4);
            chk("t1 icache_resp_valid L1", o1.irv, j == 1);
            if (j == 4) chk("t1 icache data", o4.idat, 64'hDEADBEEF_CAFEF00D);
        end
        wait_idle();
        ia = 29'h3; da = 29'h5; dt = 0;
        for (int r = 0; r < 19; r++) begin
            iv = tbl[r].iv; dv = tbl[r].dv; fl = tbl[r].fl;
            step();
            chk($sformatf("tbl[%0d] icache_req_ready", r), o4.ir, tbl[r].ir);
            chk($sformatf("tbl[%0d] dcache_req_ready", r), o4.dr, tbl[r].dr);
            chk($sformatf("tbl[%0d] icache_resp_valid", r), o4.irv, tbl[r].irv);
            chk($sformatf("tbl[%0d] dcache_resp_valid", r), o4.drv, tbl[r].drv);
        end
        wait_idle();
        dv = 1; dt = 1; da = 29'h20; dd = 64'h1122334455667788;
        step();
        idle_in();
        for (int j = 1; j <= 4; j++) begin
            step();
            chk("t3 write ack", o4.drv, j == 4);
        end
        chk("t3 write echo", o4.ddat, 64'h1122334455667788);
        wait_idle();
        iv = 1; ia = 29'h20;
        step();
        iv = 0;
        for (int j = 1; j <= 4; j++) step();
        chk("t3 readback valid", o4.irv, 1);
        chk("t3 readback data", o4.idat, 64'h1122334455667788);
        wait_idle();
        dv = 1; dt = 0; da = 29'h7;
        step();
        dv = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        for (int j = 0; j < 6; j++) begin
            step();
            chk("t5 dropped request response", o4.drv, 0);
        end
        dv = 1; da = 29'h8;
        step();
        dv = 0;
        for (int j = 1; j <= 4; j++) step();
        chk("t5 post-reset read valid", o4.drv, 1);
        chk("t5 post-reset read data", o4.ddat, pre(8));
        wait_idle();
        iv = 1; ia = 29'h0;
        step();
        ia = 29'h1;
        step();
        chk("t6 first resp L1", o1.irv, 1);
        chk("t6 first data L1", o1.idat, pre(0));
        step();
        chk("t6 gap L1", o1.irv, 0);
        iv = 0;
        step();
        chk("t6 second resp L1", o1.irv, 1);
        chk("t6 second data L1", o1.idat, pre(1));
        wait_idle();
        for (int c = 0; c < 3000; c++) begin
            iv = $urandom_range(0, 2) == 0;
            ia = 29'($urandom) & 29'h1FFF_FC1F;
            dv = $urandom_range(0, 1) == 1;
            dt = $urandom_range(0, 1) == 1;
            da = 29'($urandom) & 29'h1FFF_FC1F;
            dd = {$urandom, $urandom};
            fl = $urandom_range(0, 7) == 0;
            rst = $urandom_range(0, 149) == 0;
            step();
        end
        rst = 0;
        wait_idle();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
